mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 42 ++++
 rtl/mem_responder_ram_256x16.sv | 23 ++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: command codes, address map,
// controller states and the address decode helper.
package mem_responder_pkg;

  localparam int ADDR_W = 9;
  localparam int LED_W  = 8;
  localparam int SW_W   = 8;

  typedef enum logic [1:0] {
    MNONE    = 2'b00,
    MREAD    = 2'b01,
    MWRITE   = 2'b10,
    MILLEGAL = 2'b11
  } mem_cmd_e;

  localparam logic [ADDR_W-1:0] RAM_BASE = 9'h000;
  localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
  localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_LED,
    RGN_SW,
    RGN_NONE
  } region_e;

  function automatic region_e addr_region(input logic [ADDR_W-1:0] addr,
                                          input int unsigned ram_words);
    region_e rgn;
    rgn = RGN_NONE;
    if (32'(addr - RAM_BASE) < ram_words) rgn = RGN_RAM;
    else if (addr == LED_ADDR)            rgn = RGN_LED;
    else if (addr == SW_ADDR)             rgn = RGN_SW;
    return rgn;
  endfunction

endpackage

// File: rtl/mem_responder_ram_256x16.sv
// Single-port RAM with synchronous write and registered (enabled) read.
// Contents are never reset; the owner zeroes them after reset.
module ram_256x16 #(
  parameter int RAM_WORDS = 256,
  parameter int DATA_W    = 16,
  parameter int AW        = $clog2(RAM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder: RAM, LED register and synchronized switch port,
// with a post-reset RAM clear sequence and a sticky error flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              err
);

  localparam int            AW       = $clog2(RAM_WORDS);
  localparam logic [AW-1:0] CLR_LAST = AW'(RAM_WORDS - 1);

  state_e            state, state_nxt;
  logic [AW-1:0]     clr_cnt, clr_cnt_nxt;
  region_e           region;
  logic              rd_fire, led_we, err_set;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, reg_word;
  logic [SW_W-1:0]   sw_p0, sw_p1;
  logic              vld_p1, rd_ram_p1;
  logic [DATA_W-1:0] rd_reg_p1;

  assign region = addr_region(mem_addr, RAM_WORDS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // The RAM port belongs to the clear sequencer in INIT, to the command path in SERVE.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    rd_fire     = 1'b0;
    led_we      = 1'b0;
    err_set     = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = AW'(mem_addr - RAM_BASE);
    ram_wdata   = write_data;
    unique case (state)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
        if (clr_cnt == CLR_LAST) state_nxt = ST_SERVE;
        else                     clr_cnt_nxt = clr_cnt + AW'(1);
        if (mem_cmd_e'(mem_cmd) != MNONE) err_set = 1'b1;
      end
      ST_SERVE: begin
        unique case (mem_cmd_e'(mem_cmd))
          MREAD: begin
            rd_fire = 1'b1;
            if (region == RGN_RAM)  ram_re  = 1'b1;
            if (region == RGN_NONE) err_set = 1'b1;
          end
          MWRITE: begin
            unique case (region)
              RGN_RAM: ram_we  = 1'b1;
              RGN_LED: led_we  = 1'b1;
              default: err_set = 1'b1;
            endcase
          end
          MILLEGAL: err_set = 1'b1;
          default:  ;
        endcase
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    reg_word = '0;
    unique case (region)
      RGN_LED: reg_word = DATA_W'(led);
      RGN_SW:  reg_word = DATA_W'(sw_p1);
      default: reg_word = '0;
    endcase
  end

  ram_256x16 #(
    .RAM_WORDS(RAM_WORDS),
    .DATA_W   (DATA_W),
    .AW       (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Stage p0/p1: switch synchronizer and read response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_p0     <= '0;
      sw_p1     <= '0;
      vld_p1    <= 1'b0;
      rd_ram_p1 <= 1'b0;
      rd_reg_p1 <= '0;
      led       <= '0;
      err       <= 1'b0;
    end else begin
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
      vld_p1 <= rd_fire;
      if (rd_fire) begin
        rd_ram_p1 <= (region == RGN_RAM);
        rd_reg_p1 <= reg_word;
      end
      if (led_we)  led <= write_data[LED_W-1:0];
      if (err_set) err <= 1'b1;
    end
  end

  // Both sources are registers that only change on an accepted read, so the mux output holds.
  assign read_data  = rd_ram_p1 ? ram_rdata : rd_reg_p1;
  assign read_valid = vld_p1;
  assign busy       = (state == ST_INIT);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against an address-map level reference model.
module tb_mem_responder;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_ILL   = 2'b11;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw;
  logic [15:0] read_data;
  logic        read_valid;
  logic [7:0]  led;
  logic        busy;
  logic        err;

  mem_responder #(.RAM_WORDS(256), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .sw        (sw),
    .read_data (read_data),
    .read_valid(read_valid),
    .led       (led),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] ram_m [256];
  logic [7:0]  led_m;
  bit          err_m;
  int          init_left;
  logic [15:0] rd_m;
  bit          vld_m;
  logic [7:0]  sw_d1_m, sw_sync_m;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("busy",  32'(busy),       32'(init_left > 0));
    check_val("rvld",  32'(read_valid), 32'(vld_m));
    check_val("rdata", 32'(read_data),  32'(rd_m));
    check_val("led",   32'(led),        32'(led_m));
    check_val("err",   32'(err),        32'(err_m));
  endtask

  task automatic apply_reset();
    #3;
    mem_cmd = C_NONE;
    reset   = 1'b0;
    init_left = 256;
    led_m = 8'h00;
    err_m = 1'b0;
    rd_m  = 16'h0000;
    vld_m = 1'b0;
    sw_d1_m   = 8'h00;
    sw_sync_m = 8'h00;
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cycle(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    @(posedge clk);
    vld_m = 1'b0;
    if (init_left > 0) begin
      ram_m[256 - init_left] = 16'h0000;
      init_left--;
      if (cmd != C_NONE) err_m = 1'b1;
    end else begin
      case (cmd)
        C_READ: begin
          vld_m = 1'b1;
          if (addr < 9'd256)       rd_m = ram_m[addr[7:0]];
          else if (addr == 9'h100) rd_m = {8'h00, led_m};
          else if (addr == 9'h140) rd_m = {8'h00, sw_sync_m};
          else begin
            rd_m  = 16'h0000;
            err_m = 1'b1;
          end
        end
        C_WRITE: begin
          if (addr < 9'd256)       ram_m[addr[7:0]] = wd;
          else if (addr == 9'h100) led_m = wd[7:0];
          else                     err_m = 1'b1;
        end
        C_ILL:   err_m = 1'b1;
        default: ;
      endcase
    end
    sw_sync_m = sw_d1_m;
    sw_d1_m   = sw;
    #1;
    check_outputs();
  endtask

  function automatic logic [8:0] pick_addr(input bit mapped_only);
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6)       return 9'($urandom_range(0, 15));
    else if (r == 6) return 9'h100;
    else if (r == 7) return 9'h140;
    else if (mapped_only) return 9'($urandom_range(0, 255));
    else             return 9'($urandom_range(0, 511));
  endfunction

  task automatic random_run(input int n, input bit mapped_only);
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      c = mapped_only ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
      cycle(c, pick_addr(mapped_only), 16'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_cmd = C_NONE;
    mem_addr = '0;
    write_data = '0;
    sw = 8'h00;

    apply_reset();
    for (int i = 0; i < 10; i++) cycle(C_NONE, 9'h000, 16'h0000);
    cycle(C_WRITE, 9'h010, 16'hDEAD);
    check_val("init_wr_err", 32'(err), 32'd1);
    for (int i = 11; i < 100; i++) cycle(C_NONE, 9'h000, 16'h0000);

    apply_reset();
    for (int i = 0; i < 255; i++) cycle(C_NONE, 9'h000, 16'h0000);
    check_val("busy_255", 32'(busy), 32'd1);
    cycle(C_NONE, 9'h000, 16'h0000);
    check_val("busy_256", 32'(busy), 32'd0);

    cycle(C_READ, 9'h0A5, 16'h0000);
    check_val("rd_a5", 32'(read_data), 32'h0000);
    cycle(C_WRITE, 9'h010, 16'hBEEF);
    cycle(C_READ, 9'h010, 16'h0000);
    check_val("rd_beef", 32'(read_data), 32'hBEEF);
    cycle(C_NONE, 9'h000, 16'h0000);

    cycle(C_WRITE, 9'h100, 16'h12C3);
    check_val("led_c3", 32'(led), 32'hC3);
    cycle(C_READ, 9'h100, 16'h0000);
    check_val("rd_led", 32'(read_data), 32'h00C3);
    sw = 8'h5A;
    repeat (3) cycle(C_NONE, 9'h000, 16'h0000);
    cycle(C_READ, 9'h140, 16'h0000);
    check_val("rd_sw", 32'(read_data), 32'h005A);

    cycle(C_WRITE, 9'h000, 16'h1111);
    cycle(C_WRITE, 9'h001, 16'h2222);
    cycle(C_WRITE, 9'h002, 16'h3333);
    cycle(C_READ,  9'h000, 16'h0000);
    check_val("b2b_0", 32'(read_data), 32'h1111);
    cycle(C_READ,  9'h001, 16'h0000);
    check_val("b2b_1", 32'(read_data), 32'h2222);
    cycle(C_READ,  9'h002, 16'h0000);
    check_val("b2b_2", 32'(read_data), 32'h3333);

    random_run(1500, 1'b1);

    cycle(C_WRITE, 9'h020, 16'hA5A5);
    cycle(C_READ, 9'h1FF, 16'h0000);
    check_val("unmapped_err", 32'(err), 32'd1);
    cycle(C_ILL, 9'h020, 16'hFFFF);
    cycle(C_WRITE, 9'h140, 16'h00FF);
    cycle(C_READ, 9'h020, 16'h0000);
    check_val("ill_no_wr", 32'(read_data), 32'hA5A5);
    random_run(800, 1'b0);

    apply_reset();
    for (int i = 0; i < 256; i++) cycle(C_NONE, 9'h000, 16'h0000);
    random_run(400, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
